// File: rtl/risc_idecode.sv
// Qrisc32 decode stage: expands instruction words into pipe_struct records
// and hands them to EX through a primary register backed by one skid slot.
package risc_pack;
    localparam logic [3:0] OP_LDR    = 4'd0;
    localparam logic [3:0] OP_STR    = 4'd1;
    localparam logic [3:0] OP_JMPUNC = 4'd2;
    localparam logic [3:0] OP_JMPF   = 4'd3;
    localparam logic [3:0] OP_ALU    = 4'd4;
    localparam logic [3:0] OP_LDRF   = 4'd5;

    typedef struct packed {
        logic        read_mem;
        logic        write_mem;
        logic        write_reg;
        logic        and_op;
        logic        or_op;
        logic        xor_op;
        logic        add_op;
        logic        mul_op;
        logic        shl_op;
        logic        shr_op;
        logic        cmp_op;
        logic        ldrf_op;
        logic        jmpunc;
        logic        jmpz;
        logic        jmpnz;
        logic        jmpc;
        logic        jmpnc;
        logic        incr_r2_enable;
        logic [3:0]  incr_r2;
        logic [4:0]  src_r1;
        logic [4:0]  src_r2;
        logic [4:0]  dst_r;
        logic [31:0] val_r1;
        logic [31:0] val_r2;
        logic [31:0] val_dst;
    } pipe_struct;
endpackage

module risc_idecode
    import risc_pack::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic [4:0]      rf_raddr3,
    input  logic [31:0]     rf_rdata1,
    input  logic [31:0]     rf_rdata2,
    input  logic [31:0]     rf_rdata3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output pipe_struct      out_pipe,
    output logic            illegal,
    output logic [15:0]     illegal_cnt
);
    pipe_struct  dec, prim_q, prim_d, skid_q, skid_d;
    logic        prim_vld_q, prim_vld_d, skid_vld_q, skid_vld_d;
    logic        illegal_q, illegal_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;
    logic        ill, accept, incr_base;
    logic [31:0] pc_ext, off;

    assign rf_raddr1 = in_instr[9:5];
    assign rf_raddr2 = in_instr[14:10];
    assign rf_raddr3 = in_instr[4:0];

    always_comb begin
        pc_ext = '0;
        pc_ext[PC_W-1:0] = in_pc;
    end

    assign off       = in_instr[25] ? rf_rdata2 : {{17{in_instr[24]}}, in_instr[24:10]};
    assign incr_base = (in_instr[23:22] != 2'b00);

    always_comb begin
        dec                = '0;
        ill                = 1'b0;
        dec.src_r1         = in_instr[9:5];
        dec.src_r2         = in_instr[14:10];
        dec.dst_r          = in_instr[4:0];
        dec.incr_r2        = {1'b0, in_instr[24:22]};
        dec.incr_r2_enable = incr_base;
        case (in_instr[31:28])
            OP_LDR: begin
                dec.incr_r2_enable = incr_base & in_instr[25];
                dec.write_reg      = 1'b1;
                case (in_instr[27:26])
                    2'd0: begin dec.or_op = 1'b1; dec.val_r1 = rf_rdata1; end
                    2'd1: begin
                        dec.or_op  = 1'b1;
                        dec.val_r1 = {in_instr[20:5], 16'h0};
                        dec.val_r2 = {16'h0, rf_rdata3[15:0]};
                    end
                    2'd2: begin
                        dec.or_op  = 1'b1;
                        dec.val_r1 = {rf_rdata3[31:16], 16'h0};
                        dec.val_r2 = {16'h0, in_instr[20:5]};
                    end
                    default: begin dec.read_mem = 1'b1; dec.val_r1 = rf_rdata1; dec.val_r2 = off; end
                endcase
            end
            OP_STR: begin
                dec.incr_r2_enable = incr_base & in_instr[25];
                dec.write_mem      = 1'b1;
                dec.val_r1         = rf_rdata1;
                dec.val_r2         = off;
                dec.val_dst        = rf_rdata3;
                ill                = (in_instr[27:26] != 2'd3);
            end
            OP_JMPUNC: begin
                dec.incr_r2_enable = incr_base & in_instr[25];
                dec.jmpunc         = 1'b1;
                case (in_instr[27:26])
                    2'd0: dec.val_dst = {pc_ext[31:26], in_instr[25:0]};
                    2'd1: begin dec.val_r1 = pc_ext; dec.val_r2 = off; end
                    2'd2: begin
                        dec.write_reg = 1'b1;
                        dec.val_r1    = pc_ext;
                        dec.val_r2    = off;
                        dec.val_dst   = pc_ext + 32'd1;
                    end
                    default: dec.val_dst = rf_rdata3;
                endcase
            end
            OP_JMPF: begin
                dec.incr_r2_enable = incr_base & in_instr[25];
                dec.val_r1         = pc_ext;
                dec.val_r2         = off;
                {dec.jmpz, dec.jmpnz, dec.jmpc, dec.jmpnc} = 4'b1000 >> in_instr[27:26];
            end
            OP_ALU: begin
                dec.val_r1    = rf_rdata1;
                dec.val_r2    = rf_rdata2;
                dec.write_reg = (in_instr[27:25] != 3'd7);
                {dec.and_op, dec.or_op, dec.xor_op, dec.add_op,
                 dec.mul_op, dec.shl_op, dec.shr_op, dec.cmp_op} = 8'h80 >> in_instr[27:25];
            end
            OP_LDRF: begin
                // condition rides on the branch flags; EX treats them as a select
                dec.ldrf_op   = 1'b1;
                dec.write_reg = 1'b1;
                dec.val_r1    = rf_rdata1;
                dec.val_r2    = rf_rdata2;
                {dec.jmpz, dec.jmpnz, dec.jmpc, dec.jmpnc} = 4'b1000 >> in_instr[27:26];
                ill           = in_instr[25];
            end
            default: ill = 1'b1;
        endcase
        if (ill || in_instr == 32'h0) dec = '0;
    end

    assign in_ready = !skid_vld_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        prim_d        = prim_q;
        prim_vld_d    = prim_vld_q;
        skid_d        = skid_q;
        skid_vld_d    = skid_vld_q;
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            prim_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (out_ready) begin
                prim_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            // skid is only used when the primary slot is held by backpressure
            if (!prim_vld_q || out_ready) begin
                prim_d     = dec;
                prim_vld_d = 1'b1;
            end else begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
            illegal_d = ill;
            if (ill && illegal_cnt_q != 16'hFFFF) illegal_cnt_d = illegal_cnt_q + 16'd1;
        end else if (out_ready) begin
            prim_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            prim_q        <= '0;
            prim_vld_q    <= 1'b0;
            skid_q        <= '0;
            skid_vld_q    <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            prim_q        <= prim_d;
            prim_vld_q    <= prim_vld_d;
            skid_q        <= skid_d;
            skid_vld_q    <= skid_vld_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = prim_vld_q;
    assign out_pipe    = prim_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_risc_idecode.sv
// Directed bench for risc_idecode: decode cases, backpressure, illegal codes,
// flush and asynchronous reset.
module tb_risc_idecode;
    import risc_pack::*;

    logic        clk = 1'b0;
    logic        areset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_raddr3;
    logic [31:0] rf_rdata1, rf_rdata2, rf_rdata3;
    logic [15:0] illegal_cnt;
    pipe_struct  out_pipe;

    int checks = 0;
    int errors = 0;

    risc_idecode #(.PC_W(32)) dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pipe(out_pipe), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        out_ready = 1'b1; rf_rdata1 = '0; rf_rdata2 = '0; rf_rdata3 = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: out_valid=%b in_ready=%b illegal=%b, want 0 1 0", out_valid, in_ready, illegal);
        end
        checks++;
        if (out_pipe !== '0 || illegal_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_data: out_pipe=%h cnt=%h, want 0", out_pipe, illegal_cnt);
        end
        @(negedge clk);
        areset = 1'b1;
        tick();
    endtask

    task automatic test_alu_add();
        pipe_struct exp;
        in_instr = {4'd4, 3'd3, 3'b000, 7'd0, 5'd2, 5'd1, 5'd3};
        rf_rdata1 = 32'd5; rf_rdata2 = 32'd7; rf_rdata3 = 32'hDEAD;
        in_valid = 1'b1;
        #1;
        checks++;
        if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2 || rf_raddr3 !== 5'd3) begin
            errors++; $display("FAIL raddr: got %0d %0d %0d, want 1 2 3", rf_raddr1, rf_raddr2, rf_raddr3);
        end
        tick();
        in_valid = 1'b0;
        exp = '0;
        exp.add_op = 1'b1; exp.write_reg = 1'b1; exp.val_r1 = 32'd5; exp.val_r2 = 32'd7;
        exp.src_r1 = 5'd1; exp.src_r2 = 5'd2; exp.dst_r = 5'd3;
        checks++;
        if (out_valid !== 1'b1 || out_pipe !== exp) begin
            errors++; $display("FAIL alu_add: valid=%b pipe=%h, want 1 %h", out_valid, out_pipe, exp);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL alu_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_ldrh_ldrl();
        pipe_struct exp;
        logic [31:0] c1, c2;
        c1 = {4'd0, 2'b01, 5'd0, 16'h1234, 5'd4};
        c2 = {4'd0, 2'b10, 5'd0, 16'h5678, 5'd4};
        rf_rdata1 = 32'h1111_1111; rf_rdata2 = 32'h2222_2222; rf_rdata3 = 32'h0;
        in_valid = 1'b1; in_instr = c1;
        tick();
        in_instr = c2;
        exp = '0;
        exp.write_reg = 1'b1; exp.or_op = 1'b1; exp.val_r1 = 32'h1234_0000; exp.val_r2 = 32'h0;
        exp.src_r1 = c1[9:5]; exp.src_r2 = c1[14:10]; exp.dst_r = 5'd4;
        checks++;
        if (out_valid !== 1'b1 || out_pipe !== exp) begin
            errors++; $display("FAIL ldrh: valid=%b pipe=%h, want 1 %h", out_valid, out_pipe, exp);
        end
        tick();
        in_valid = 1'b0;
        exp = '0;
        exp.write_reg = 1'b1; exp.or_op = 1'b1; exp.val_r1 = 32'h0; exp.val_r2 = 32'h0000_5678;
        exp.src_r1 = c2[9:5]; exp.src_r2 = c2[14:10]; exp.dst_r = 5'd4;
        checks++;
        if (out_valid !== 1'b1 || out_pipe !== exp) begin
            errors++; $display("FAIL ldrl: valid=%b pipe=%h, want 1 %h", out_valid, out_pipe, exp);
        end
        tick();
    endtask

    task automatic test_ldrp();
        pipe_struct exp;
        rf_rdata1 = 32'h100; rf_rdata2 = 32'h10; rf_rdata3 = 32'h0;
        in_valid = 1'b1; in_instr = {4'd0, 2'b11, 1'b1, 3'b111, 7'd0, 5'd2, 5'd1, 5'd5};
        tick();
        in_instr = {4'd0, 2'b11, 1'b0, 15'h7FFF, 5'd1, 5'd5};
        exp = '0;
        exp.read_mem = 1'b1; exp.write_reg = 1'b1; exp.val_r1 = 32'h100; exp.val_r2 = 32'h10;
        exp.incr_r2 = 4'd7; exp.incr_r2_enable = 1'b1;
        exp.src_r1 = 5'd1; exp.src_r2 = 5'd2; exp.dst_r = 5'd5;
        checks++;
        if (out_pipe !== exp) begin
            errors++; $display("FAIL ldrp_reg: pipe=%h, want %h", out_pipe, exp);
        end
        tick();
        in_valid = 1'b0;
        exp = '0;
        exp.read_mem = 1'b1; exp.write_reg = 1'b1; exp.val_r1 = 32'h100; exp.val_r2 = 32'hFFFF_FFFF;
        exp.incr_r2 = 4'd7; exp.incr_r2_enable = 1'b0;
        exp.src_r1 = 5'd1; exp.src_r2 = 5'd31; exp.dst_r = 5'd5;
        checks++;
        if (out_pipe !== exp) begin
            errors++; $display("FAIL ldrp_imm: pipe=%h, want %h", out_pipe, exp);
        end
        tick();
    endtask

    task automatic test_jumps();
        pipe_struct exp;
        logic [31:0] c;
        in_pc = 32'h0000_0040;
        c = {4'd2, 2'b10, 1'b0, 15'd5, 5'd0, 5'd0};
        in_valid = 1'b1; in_instr = c;
        tick();
        exp = '0;
        exp.jmpunc = 1'b1; exp.write_reg = 1'b1; exp.val_r1 = 32'h40; exp.val_r2 = 32'd5;
        exp.val_dst = 32'h41; exp.src_r2 = 5'd5;
        checks++;
        if (out_pipe !== exp) begin
            errors++; $display("FAIL call: pipe=%h, want %h", out_pipe, exp);
        end
        in_pc = 32'hFC00_0040;
        c = {4'd2, 2'b00, 26'h123456};
        in_instr = c;
        tick();
        in_valid = 1'b0;
        exp = '0;
        exp.jmpunc = 1'b1; exp.val_dst = 32'hFC12_3456;
        exp.src_r1 = c[9:5]; exp.src_r2 = c[14:10]; exp.dst_r = c[4:0];
        exp.incr_r2 = {1'b0, c[24:22]}; exp.incr_r2_enable = c[25] & (c[23:22] != 2'b00);
        checks++;
        if (out_pipe !== exp) begin
            errors++; $display("FAIL jmp: pipe=%h, want %h", out_pipe, exp);
        end
        in_pc = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        logic [4:0]  got [$];
        int idx;
        logic acc, xfer;
        for (int i = 0; i < 4; i++) w[i] = {4'd4, 3'd3, 3'b000, 7'd0, 5'd2, 5'd1, 5'(i + 1)};
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = w[0]; tick();
        in_instr = w[1]; tick();
        in_instr = w[2];
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pipe.dst_r !== 5'd1) begin
            errors++; $display("FAIL bp_full: in_ready=%b valid=%b dst=%0d, want 0 1 1", in_ready, out_valid, out_pipe.dst_r);
        end
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || out_pipe.dst_r !== 5'd1) begin
            errors++; $display("FAIL bp_stable: in_ready=%b dst=%0d, want 0 1", in_ready, out_pipe.dst_r);
        end
        out_ready = 1'b1; idx = 2;
        for (int cyc = 0; cyc < 12 && got.size() < 4; cyc++) begin
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) got.push_back(out_pipe.dst_r);
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) in_instr = w[idx];
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d outputs, want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 5'(i + 1)) begin
                    errors++; $display("FAIL bp_order[%0d]: dst=%0d, want %0d", i, got[i], i + 1);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = {4'hF, 28'h0000123};
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pipe !== '0 || illegal !== 1'b1 || illegal_cnt !== 16'd1) begin
            errors++; $display("FAIL illegal_op: valid=%b pipe=%h ill=%b cnt=%0d, want 1 0 1 1", out_valid, out_pipe, illegal, illegal_cnt);
        end
        tick();
        checks++;
        if (illegal !== 1'b0 || illegal_cnt !== 16'd1) begin
            errors++; $display("FAIL illegal_pulse: ill=%b cnt=%0d, want 0 1", illegal, illegal_cnt);
        end
        in_valid = 1'b1; in_instr = {4'd1, 2'b00, 26'h0000421};
        tick();
        in_instr = {4'd5, 2'b01, 1'b1, 25'h0000421};
        tick();
        in_valid = 1'b0;
        checks++;
        if (illegal !== 1'b1 || illegal_cnt !== 16'd3 || out_pipe !== '0) begin
            errors++; $display("FAIL illegal_sub: ill=%b cnt=%0d pipe=%h, want 1 3 0", illegal, illegal_cnt, out_pipe);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = {4'd4, 3'd3, 3'b000, 7'd0, 5'd2, 5'd1, 5'd9};
        tick();
        flush = 1'b1; in_instr = {4'hF, 28'h0};
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || illegal_cnt !== 16'd3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ill: valid=%b ill=%b cnt=%0d rdy=%b, want 0 0 3 1", out_valid, illegal, illegal_cnt, in_ready);
        end
        in_valid = 1'b1; in_instr = {4'd4, 3'd0, 25'h1};
        tick(); tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_skid: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_after: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_instr = {4'hE, 28'h0};
        tick();
        in_valid = 1'b0;
        #2 areset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || illegal_cnt !== 16'd0 || illegal !== 1'b0 || out_pipe !== '0) begin
            errors++; $display("FAIL async_rst: valid=%b cnt=%0d ill=%b pipe=%h, want 0 0 0 0", out_valid, illegal_cnt, illegal, out_pipe);
        end
        @(negedge clk);
        areset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_ldrh_ldrl();
        test_ldrp();
        test_jumps();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/risc_idecode.md
# risc_idecode

Instruction decode stage for the Qrisc32 pipeline. It accepts 32-bit instruction words with their PC over a valid/ready handshake and reads source operands from the register file. Each word is expanded into a `risc_pack::pipe_struct` control/operand record, which is delivered to the EX stage through a two-entry skid buffer. It is the consuming end of the `risc_pack` encoding: the assembler and testbench generators produce these codes, and this block interprets them.

## Interface
- `PC_W`, 32, PC width; `pc` is zero-extended to 32 bits where it enters `val_*`.
- `clk` in 1: single clock, rising edge.
- `areset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_instr`/`in_pc` valid.
- `in_ready` out 1: stage can accept a word this cycle.
- `in_instr` in 32: instruction code.
- `in_pc` in PC_W: address of `in_instr`.
- `rf_raddr1`, `rf_raddr2`, `rf_raddr3` out 5 each: combinational, equal to `in_instr[9:5]`, `[14:10]` and `[4:0]`.
- `rf_rdata1`, `rf_rdata2`, `rf_rdata3` in 32 each: same-cycle register file read data.
- `flush` in 1: synchronous kill of all held and incoming words.
- `out_valid` out 1: `out_pipe` valid.
- `out_ready` in 1: EX accepts `out_pipe`.
- `out_pipe` out `$bits(pipe_struct)`: decoded record.
- `illegal` out 1: one-cycle pulse when an illegal code is accepted.
- `illegal_cnt` out 16: saturating count of illegal codes.

## Operation
- Common fields: `src_r1=[9:5]`, `src_r2=[14:10]`, `dst_r=[4:0]`. All unlisted flags are 0.
- Operand symbols: R1/R2/Rd are `rf_rdata1/2/3`.
- `off` = `code[25]` ? R2 : `sext(code[24:10])`.
- Incrementer: `incr_r2={1'b0,code[24:22]}`. `incr_r2_enable=(code[23:22]!=0)`, additionally gated by `code[25]` for LDR/STR/JMPUNC/JMPF.
- LDR type 0: `write_reg`, `or_op`, `val_r1`=R1, `val_r2`=0.
- LDRH: `write_reg`, `or_op`, `val_r1={code[20:5],16'h0}`, `val_r2={16'h0,Rd[15:0]}`.
- LDRL: `write_reg`, `or_op`, `val_r1={Rd[31:16],16'h0}`, `val_r2={16'h0,code[20:5]}`.
- LDRP: `read_mem`, `write_reg`, `val_r1`=R1, `val_r2`=`off`.
- STRP: `write_mem`, `val_r1`=R1, `val_r2`=`off`, `val_dst`=Rd. Other STR types are illegal.
- JMP: `jmpunc`, `val_dst={pc[31:26],code[25:0]}`.
- JMPR: `jmpunc`, `val_r1`=pc, `val_r2`=`off`.
- CALL: as JMPR plus `write_reg`, with `val_dst`=pc+1 (return address).
- RET: `jmpunc`, `val_dst`=Rd.
- JMPZ/JMPNZ/JMPC/JMPNC: `jmpz`/`jmpnz`/`jmpc`/`jmpnc` respectively, `val_r1`=pc, `val_r2`=`off`.
- ALU: `[27:25]` selects `and_op`/`or_op`/`xor_op`/`add_op`/`mul_op`/`shl_op`/`shr_op`/`cmp_op`. `val_r1`=R1, `val_r2`=R2. `write_reg` is set for all except CMP.
- LDRF: `ldrf_op`, `write_reg`, `val_r1`=R1, `val_r2`=R2. The condition is carried in `jmpz`/`jmpnz`/`jmpc`/`jmpnc` by `[27:26]`; EX interprets these as a select when `ldrf_op`=1. LDRF with `code[25]`=1 is illegal.
- `in_instr==0`: NOP, i.e. an all-zero record with `out_valid` still asserted.
- Opcodes 6..15 and the illegal subtypes above produce an all-zero record, pulse `illegal`, and increment `illegal_cnt`.
- Buffering: primary output register plus one skid register.
- `in_ready` = skid empty.
- When `out_ready`=0 while the primary register is full and a word is accepted, the word goes to the skid register.
- The skid register drains into the primary register on the next `out_ready`.

## Timing
- Reset: `out_valid`=0, `out_pipe`=0, skid empty, `in_ready`=1, `illegal`=0, `illegal_cnt`=0.
- Latency: a word accepted at edge N (`in_valid & in_ready`) appears on `out_pipe` with `out_valid`=1 after edge N; there are no bubbles with `out_ready` held high.
- Throughput is one word per cycle.
- `out_pipe` is stable while `out_valid & !out_ready`.
- Register operands are sampled at the acceptance edge. RAW hazards against later pipeline stages are not this block's concern.
- `flush`: at the next edge `out_valid`=0 and the skid is cleared.
- A word presented during `flush` is dropped and not counted, even if it is illegal.
- `in_ready` is 1 in the cycle after a flush.
- Accept and drain in the same cycle with the skid empty: the new word replaces the primary register directly.
- `illegal_cnt` saturates at 16'hFFFF.
- Reset asserted mid-operation clears all state immediately (asynchronously); outputs stay at reset values until the first edge after deassertion.

## Test plan
- Reset, then stream ADD R3,R1,R2 (`code={ADD,3'b000,…}`) with R1=5, R2=7 and `out_ready`=1 -> next cycle: `add_op`=1, `write_reg`=1, `val_r1`=5, `val_r2`=7, `dst_r`=3.
- LDRH R4,0x1234 then LDRL R4,0x5678 with Rd=0 -> `val_r1`=32'h1234_0000 and `val_r2`=0, then `val_r2`=32'h0000_5678; both with `or_op`=1.
- LDRP with `code[25]`=1, `[24:22]`=111, R2=0x10 -> `read_mem`=1, `val_r2`=0x10, `incr_r2`=7, `incr_r2_enable`=1.
- Same LDRP with `code[25]`=0 and `code[24:10]`=15'h7FFF -> `val_r2`=32'hFFFF_FFFF, `incr_r2_enable`=0.
- Backpressure: 4 back-to-back words with `out_ready`=0 -> two accepted, then `in_ready`=0. After `out_ready`=1, outputs arrive in order with none lost or duplicated.
- Opcode 4'hF word -> zero record, `illegal` pulse, `illegal_cnt`=1.
- An illegal word presented with `flush`=1 -> no output, `illegal_cnt` unchanged.
